port_bus_arb: RTL and testbench

PORT_BUS_ARB -- requirements
Module: port_bus_arb

---
 rtl/port_bus_arb_pkg.sv | 28 ++
 rtl/port_bus_arb_pick.sv | 31 +++
 rtl/port_bus_arb.sv | 228 ++++++++++++++++++++++
 tb/tb_port_bus_arb.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/port_bus_arb_pkg.sv
// -----------------------------------------------------------------------------
// port_bus_arb_pkg
// Shared definitions for the two-requester port bus arbiter.
//   state_t  : FSM encoding (IDLE=0, SETUP=1, STROBE=2, DONE=3)
//   grant_t  : requester index (0 = MCU bridge, 1 = LED refresh engine)
//   ADDR_W   : port address width
//   DATA_W   : port data width
//   CNT_W    : strobe down-counter width (covers strobe widths up to 15)
// -----------------------------------------------------------------------------
package port_bus_arb_pkg;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    typedef logic grant_t;

    localparam grant_t GRANT_REQ0 = 1'b0;
    localparam grant_t GRANT_REQ1 = 1'b1;

endpackage

// File: rtl/port_bus_arb_pick.sv
// -----------------------------------------------------------------------------
// port_arb_pick
// Combinational winner selection for the port bus arbiter.
//   i_req0, i_req1 : pending requests
//   i_last         : requester granted most recently
//   o_valid        : at least one request is pending
//   o_grant        : winning requester index (meaningful when o_valid)
// On a tie the requester that was NOT granted last wins. A parent that wants
// fixed priority simply ties i_last to requester 1 so requester 0 always wins.
// -----------------------------------------------------------------------------
module port_arb_pick
    import port_bus_arb_pkg::*;
(
    input  logic   i_req0,
    input  logic   i_req1,
    input  grant_t i_last,
    output logic   o_valid,
    output grant_t o_grant
);

    always_comb begin
        o_valid = i_req0 | i_req1;
        o_grant = GRANT_REQ0;
        if (i_req0 && i_req1) begin
            o_grant = (i_last == GRANT_REQ0) ? GRANT_REQ1 : GRANT_REQ0;
        end else if (i_req1) begin
            o_grant = GRANT_REQ1;
        end
    end

endmodule

// File: rtl/port_bus_arb.sv
// -----------------------------------------------------------------------------
// port_bus_arb
// Arbitrates two requesters (0: MCU bridge, 1: LED refresh engine) onto a
// single strobed port bus, one transaction at a time:
//   IDLE -> SETUP (1 cycle) -> STROBE (STB_W cycles) -> DONE (1 cycle) -> IDLE
//
// Parameter
//   STB_W         : strobe low-width in clk cycles, legal 1..15
// Ports
//   clk, rst_n    : clock, asynchronous active-low reset
//   reqN/weN      : level request (held until ackN), write(1)/read(0)
//   addrN/wdataN  : port address / write data, sampled at grant
//   ackN          : one-cycle completion pulse (DONE state)
//   rdataN        : read data, updated only by requester N's reads
//   port_wr_n     : active-low write strobe
//   port_rd_n     : active-low read strobe
//   port_addr     : port address (0 while idle)
//   port_wr_data  : port write data (0 while idle)
//   port_rd_data  : read data returned by the port block
//   busy          : high whenever the FSM is not in IDLE
//
// Configuration macro
//   PORT_ARB_RR_EN : when defined, ties are resolved round-robin using a
//                    last-grant pointer; otherwise requester 0 always wins
//                    ties and no pointer register exists.
// -----------------------------------------------------------------------------
module port_bus_arb
    import port_bus_arb_pkg::*;
#(
    parameter int STB_W = 1
)
(
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,

    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,

    output logic              port_wr_n,
    output logic              port_rd_n,
    output logic [ADDR_W-1:0] port_addr,
    output logic [DATA_W-1:0] port_wr_data,
    input  logic [DATA_W-1:0] port_rd_data,

    output logic              busy
);

    // Counter is loaded with STB_W-1 so that reaching zero marks the last
    // strobe cycle, giving exactly STB_W strobe cycles.
    localparam logic [CNT_W-1:0] STB_LOAD = CNT_W'(STB_W - 1);

    state_t            r_state;
    state_t            w_state_next;

    grant_t            r_win;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_valid;
    grant_t            w_grant;
    grant_t            w_last;
    logic              w_grant_now;
    logic              w_strobe_last;

    assign w_grant_now   = (r_state == ST_IDLE) && w_valid;
    assign w_strobe_last = (r_state == ST_STROBE) && (r_cnt == '0);

    // -------------------------------------------------------------------------
    // Tie-break pointer
    // -------------------------------------------------------------------------
`ifdef PORT_ARB_RR_EN
    grant_t r_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= GRANT_REQ0;
        end else if (w_grant_now) begin
            r_last <= w_grant;
        end
    end

    assign w_last = r_last;
`else
    // Pretending requester 1 always had the last grant makes requester 0 win
    // every tie, i.e. fixed priority.
    assign w_last = GRANT_REQ1;
`endif

    port_arb_pick u_pick (
        .i_req0  (req0),
        .i_req1  (req1),
        .i_last  (w_last),
        .o_valid (w_valid),
        .o_grant (w_grant)
    );

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_valid) begin
                    w_state_next = ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_state_next = ST_STROBE;
            end
            ST_STROBE: begin
                if (w_strobe_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Transaction datapath: request latch, strobe counter, read capture.
    // The request is copied at grant, so later changes on the requester's
    // inputs (including dropping req) cannot disturb the transaction.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win    <= GRANT_REQ0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_cnt    <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            if (w_grant_now) begin
                r_win <= w_grant;
                if (w_grant == GRANT_REQ0) begin
                    r_we    <= we0;
                    r_addr  <= addr0;
                    r_wdata <= wdata0;
                end else begin
                    r_we    <= we1;
                    r_addr  <= addr1;
                    r_wdata <= wdata1;
                end
            end

            if (r_state == ST_SETUP) begin
                r_cnt <= STB_LOAD;
            end else if ((r_state == ST_STROBE) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end

            if (w_strobe_last && !r_we) begin
                if (r_win == GRANT_REQ0) begin
                    r_rdata0 <= port_rd_data;
                end else begin
                    r_rdata1 <= port_rd_data;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // FSM: outputs, decoded from state so an asynchronous reset releases the
    // strobes and clears the bus immediately.
    // -------------------------------------------------------------------------
    always_comb begin
        port_wr_n    = 1'b1;
        port_rd_n    = 1'b1;
        port_addr    = '0;
        port_wr_data = '0;
        ack0         = 1'b0;
        ack1         = 1'b0;
        busy         = (r_state != ST_IDLE);

        if (r_state != ST_IDLE) begin
            port_addr    = r_addr;
            port_wr_data = r_wdata;
        end

        if (r_state == ST_STROBE) begin
            // Only one of the two strobes can be selected by r_we.
            port_wr_n = !r_we;
            port_rd_n = r_we;
        end

        if (r_state == ST_DONE) begin
            ack0 = (r_win == GRANT_REQ0);
            ack1 = (r_win == GRANT_REQ1);
        end
    end

    assign rdata0 = r_rdata0;
    assign rdata1 = r_rdata1;

endmodule

// File: tb/tb_port_bus_arb.sv
// -----------------------------------------------------------------------------
// tb_port_bus_arb
// Directed bench for port_bus_arb. Two instances share clk/rst_n:
//   u_d1 : STB_W = 1 (a_* signals)
//   u_d3 : STB_W = 3 (b_* signals)
// Cycle numbering: requests are driven on a falling edge, the next rising edge
// is the IDLE sampling edge, and k counts falling edges after it, so a fresh
// grant shows ack at k = STB_W+2 and a back-to-back grant at k = STB_W+3.
// -----------------------------------------------------------------------------
module tb_port_bus_arb;

`ifdef PORT_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk;
    logic rst_n;

    logic       a_req0, a_we0, a_req1, a_we1, a_ack0, a_ack1;
    logic [6:0] a_addr0, a_addr1, a_port_addr;
    logic [7:0] a_wdata0, a_wdata1, a_rdata0, a_rdata1, a_port_wr_data, a_port_rd_data;
    logic       a_port_wr_n, a_port_rd_n, a_busy;

    logic       b_req0, b_we0, b_req1, b_we1, b_ack0, b_ack1;
    logic [6:0] b_addr0, b_addr1, b_port_addr;
    logic [7:0] b_wdata0, b_wdata1, b_rdata0, b_rdata1, b_port_wr_data, b_port_rd_data;
    logic       b_port_wr_n, b_port_rd_n, b_busy;

    int checks = 0;
    int errors = 0;
    int overlap = 0;

    port_bus_arb #(.STB_W(1)) u_d1 (
        .clk(clk), .rst_n(rst_n),
        .req0(a_req0), .we0(a_we0), .addr0(a_addr0), .wdata0(a_wdata0),
        .ack0(a_ack0), .rdata0(a_rdata0),
        .req1(a_req1), .we1(a_we1), .addr1(a_addr1), .wdata1(a_wdata1),
        .ack1(a_ack1), .rdata1(a_rdata1),
        .port_wr_n(a_port_wr_n), .port_rd_n(a_port_rd_n),
        .port_addr(a_port_addr), .port_wr_data(a_port_wr_data),
        .port_rd_data(a_port_rd_data), .busy(a_busy)
    );

    port_bus_arb #(.STB_W(3)) u_d3 (
        .clk(clk), .rst_n(rst_n),
        .req0(b_req0), .we0(b_we0), .addr0(b_addr0), .wdata0(b_wdata0),
        .ack0(b_ack0), .rdata0(b_rdata0),
        .req1(b_req1), .we1(b_we1), .addr1(b_addr1), .wdata1(b_wdata1),
        .ack1(b_ack1), .rdata1(b_rdata1),
        .port_wr_n(b_port_wr_n), .port_rd_n(b_port_rd_n),
        .port_addr(b_port_addr), .port_wr_data(b_port_wr_data),
        .port_rd_data(b_port_rd_data), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Watch one instance until an ack appears (bounded). Records which
    // requester was acked, on which falling edge, strobe-low counts and the
    // bus address/data seen while a strobe was low. With drop=1 the acked
    // requester releases its request on the ack cycle.
    task automatic run_txn(input bit sel, input bit drop, input int maxc,
                           output int who, output int cyc,
                           output int wr_lo, output int rd_lo,
                           output logic [6:0] s_addr, output logic [7:0] s_data);
        logic wr_n, rd_n, ack0, ack1;
        who = -1; cyc = 0; wr_lo = 0; rd_lo = 0; s_addr = '0; s_data = '0;
        for (int k = 1; k <= maxc; k++) begin
            @(negedge clk);
            wr_n = sel ? b_port_wr_n : a_port_wr_n;
            rd_n = sel ? b_port_rd_n : a_port_rd_n;
            ack0 = sel ? b_ack0 : a_ack0;
            ack1 = sel ? b_ack1 : a_ack1;
            if (!wr_n) wr_lo++;
            if (!rd_n) rd_lo++;
            if (!wr_n && !rd_n) overlap++;
            if (!wr_n || !rd_n) begin
                s_addr = sel ? b_port_addr : a_port_addr;
                s_data = sel ? b_port_wr_data : a_port_wr_data;
            end
            if (ack0 || ack1) begin
                who = ack0 ? 0 : 1;
                cyc = k;
                if (drop) begin
                    if (sel) begin
                        if (ack0) b_req0 = 1'b0; else b_req1 = 1'b0;
                    end else begin
                        if (ack0) a_req0 = 1'b0; else a_req1 = 1'b0;
                    end
                end
                break;
            end
        end
    endtask

    initial begin
        int who, cyc, wr_lo, rd_lo, acks;
        logic [6:0] s_addr;
        logic [7:0] s_data;

        rst_n = 1'b0;
        a_req0 = 0; a_we0 = 0; a_addr0 = '0; a_wdata0 = '0;
        a_req1 = 0; a_we1 = 0; a_addr1 = '0; a_wdata1 = '0; a_port_rd_data = '0;
        b_req0 = 0; b_we0 = 0; b_addr0 = '0; b_wdata0 = '0;
        b_req1 = 0; b_we1 = 0; b_addr1 = '0; b_wdata1 = '0; b_port_rd_data = '0;

        // ---- reset state ----
        @(negedge clk); @(negedge clk);
        chk("rst_wr_n", a_port_wr_n, 1);
        chk("rst_rd_n", a_port_rd_n, 1);
        chk("rst_addr", b_port_addr, 0);
        chk("rst_wdata", b_port_wr_data, 0);
        chk("rst_busy", b_busy, 0);
        chk("rst_ack", {b_ack0, b_ack1, a_ack0, a_ack1}, 0);
        chk("rst_rdata", {b_rdata0, b_rdata1}, 0);
        rst_n = 1'b1;

        // ---- STB_W=1 write: req0 addr 21 data A5 ----
        @(negedge clk);
        a_req0 = 1; a_we0 = 1; a_addr0 = 7'h21; a_wdata0 = 8'hA5;
        run_txn(0, 1, 20, who, cyc, wr_lo, rd_lo, s_addr, s_data);
        $display("txn d1 write: who=%0d cyc=%0d wr_lo=%0d rd_lo=%0d addr=%0h data=%0h", who, cyc, wr_lo, rd_lo, s_addr, s_data);
        chk("w1_who", who, 0);
        chk("w1_latency", cyc, 3);
        chk("w1_wr_lo", wr_lo, 1);
        chk("w1_rd_lo", rd_lo, 0);
        chk("w1_addr", s_addr, 7'h21);
        chk("w1_data", s_data, 8'hA5);
        @(negedge clk);
        chk("w1_idle_addr", a_port_addr, 0);
        chk("w1_idle_data", a_port_wr_data, 0);
        chk("w1_idle_busy", a_busy, 0);

        // ---- simultaneous requests on STB_W=3, pointer at reset value 0 ----
        b_req0 = 1; b_we0 = 1; b_addr0 = 7'h10; b_wdata0 = 8'h11;
        b_req1 = 1; b_we1 = 1; b_addr1 = 7'h20; b_wdata1 = 8'h22;
        run_txn(1, 1, 20, who, cyc, wr_lo, rd_lo, s_addr, s_data);
        $display("txn tie first: who=%0d cyc=%0d wr_lo=%0d addr=%0h", who, cyc, wr_lo, s_addr);
        chk("tie1_who", who, RR ? 1 : 0);
        chk("tie1_latency", cyc, 5);
        chk("tie1_wr_lo", wr_lo, 3);
        chk("tie1_addr", s_addr, RR ? 7'h20 : 7'h10);
        run_txn(1, 1, 20, who, cyc, wr_lo, rd_lo, s_addr, s_data);
        $display("txn tie second: who=%0d cyc=%0d wr_lo=%0d addr=%0h", who, cyc, wr_lo, s_addr);
        chk("tie2_who", who, RR ? 0 : 1);
        chk("tie2_latency", cyc, 6);
        chk("tie2_data", s_data, RR ? 8'h11 : 8'h22);
        chk("tie_rdata_kept", {b_rdata0, b_rdata1}, 0);

        // ---- STB_W=3 read: req1 addr 42, port returns 3C ----
        @(negedge clk);
        b_req1 = 1; b_we1 = 0; b_addr1 = 7'h42; b_port_rd_data = 8'h3C;
        run_txn(1, 1, 20, who, cyc, wr_lo, rd_lo, s_addr, s_data);
        $display("txn d3 read: who=%0d cyc=%0d rd_lo=%0d wr_lo=%0d rdata1=%0h", who, cyc, rd_lo, wr_lo, b_rdata1);
        chk("r3_who", who, 1);
        chk("r3_latency", cyc, 5);
        chk("r3_rd_lo", rd_lo, 3);
        chk("r3_wr_lo", wr_lo, 0);
        chk("r3_addr", s_addr, 7'h42);
        chk("r3_rdata1", b_rdata1, 8'h3C);
        b_port_rd_data = 8'h00;
        @(negedge clk); @(negedge clk);
        chk("r3_rdata1_held", b_rdata1, 8'h3C);
        chk("r3_rdata0_untouched", b_rdata0, 0);

        // ---- req0 read, dropped and inputs changed one cycle after grant ----
        b_req0 = 1; b_we0 = 0; b_addr0 = 7'h05; b_port_rd_data = 8'h77;
        @(negedge clk);
        b_req0 = 0; b_we0 = 1; b_addr0 = 7'h7F;
        run_txn(1, 0, 20, who, cyc, wr_lo, rd_lo, s_addr, s_data);
        $display("txn drop: who=%0d cyc=%0d rd_lo=%0d wr_lo=%0d addr=%0h rdata0=%0h", who, cyc, rd_lo, wr_lo, s_addr, b_rdata0);
        chk("drop_who", who, 0);
        chk("drop_latency", cyc, 4);
        chk("drop_rd_lo", rd_lo, 3);
        chk("drop_wr_lo", wr_lo, 0);
        chk("drop_addr", s_addr, 7'h05);
        chk("drop_rdata0", b_rdata0, 8'h77);
        chk("drop_rdata1_kept", b_rdata1, 8'h3C);
        acks = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (b_ack0 || b_ack1) acks++;
        end
        chk("drop_no_regrant", acks, 0);
        chk("drop_busy", b_busy, 0);

        // ---- reset during STROBE ----
        b_req1 = 1; b_we1 = 1; b_addr1 = 7'h33; b_wdata1 = 8'h44;
        @(negedge clk); @(negedge clk);
        chk("rs_in_strobe", b_port_wr_n, 0);
        rst_n = 1'b0;
        #1;
        $display("txn reset mid-strobe: wr_n=%0b rd_n=%0b busy=%0b ack1=%0b addr=%0h", b_port_wr_n, b_port_rd_n, b_busy, b_ack1, b_port_addr);
        chk("rs_wr_n", b_port_wr_n, 1);
        chk("rs_rd_n", b_port_rd_n, 1);
        chk("rs_busy", b_busy, 0);
        chk("rs_addr", b_port_addr, 0);
        b_req1 = 0;
        acks = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (b_ack0 || b_ack1) acks++;
        end
        chk("rs_no_ack", acks, 0);
        chk("rs_rdata_clr", {b_rdata0, b_rdata1}, 0);
        b_req0 = 1; b_we0 = 1; b_addr0 = 7'h12; b_wdata0 = 8'h34;
        rst_n = 1'b1;
        run_txn(1, 1, 20, who, cyc, wr_lo, rd_lo, s_addr, s_data);
        $display("txn after reset: who=%0d cyc=%0d wr_lo=%0d addr=%0h data=%0h", who, cyc, wr_lo, s_addr, s_data);
        chk("rs_new_who", who, 0);
        chk("rs_new_latency", cyc, 5);
        chk("rs_new_wr_lo", wr_lo, 3);
        chk("rs_new_data", s_data, 8'h34);

        // ---- continuous requests from both, 8 transactions ----
        // Last grant before this run is requester 0.
        @(negedge clk);
        b_req0 = 1; b_we0 = 1; b_addr0 = 7'h01; b_wdata0 = 8'hA0;
        b_req1 = 1; b_we1 = 1; b_addr1 = 7'h02; b_wdata1 = 8'hB1;
        for (int t = 0; t < 8; t++) begin
            run_txn(1, 0, 20, who, cyc, wr_lo, rd_lo, s_addr, s_data);
            $display("txn cont %0d: who=%0d cyc=%0d wr_lo=%0d", t, who, cyc, wr_lo);
            chk($sformatf("cont%0d_who", t), who, RR ? ((t % 2 == 0) ? 1 : 0) : 0);
            chk($sformatf("cont%0d_latency", t), cyc, (t == 0) ? 5 : 6);
        end
        b_req0 = 0; b_req1 = 0;
        @(negedge clk); @(negedge clk);
        chk("cont_busy_end", b_busy, 0);
        chk("no_overlap", overlap, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
